// File: rtl/cpu_nios_sevseg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_nios_sevseg_pkg
// Brief   : Shared definitions for the alarm-clock 7-segment scheduler:
//           register addresses, scan-state encoding and the glyph table.
// Revision: 1.0 - initial release
// ============================================================================
package cpu_nios_sevseg_pkg;

  // Avalon word addresses of the register file
  localparam logic [1:0] REG_DIGITS    = 2'd0;
  localparam logic [1:0] REG_CTRL      = 2'd1;
  localparam logic [1:0] REG_BLINK_DIV = 2'd2;
  localparam logic [1:0] REG_STATUS    = 2'd3;

  // Scan sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SNAP = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } scan_state_t;

  // All segments off (active-low)
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g..a} glyphs indexed by BCD value; 10-15 are blank
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage
`default_nettype wire

// File: rtl/cpu_nios_sevseg_decoder.sv
`default_nettype none
// ============================================================================
// Module  : cpu_nios_sevseg_decoder
// Brief   : Combinational BCD -> active-low 7-segment decoder, shared by all
//           digits through the scan sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module cpu_nios_sevseg_decoder
  import cpu_nios_sevseg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Table lookup; non-decimal codes map to a blank glyph
  assign o_seg = GLYPH_TABLE[i_bcd];

endmodule
`default_nettype wire

// File: rtl/cpu_nios_sevseg_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : cpu_nios_sevseg_scheduler
// Brief   : Avalon-MM slave owning the HH:MM 7-segment display. Staged digit
//           writes are snapshotted and scanned through one shared decoder so
//           a scan never mixes old and new digit values; a prescaled blink
//           engine can flash selected digits.
//           Build option: LEADING_ZERO_BLANK_EN blanks a zero hours-tens digit.
// Revision: 1.0 - initial release
// ============================================================================
module cpu_nios_sevseg_scheduler
  import cpu_nios_sevseg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_W      = 24
)(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [1:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    scan_busy
);

  localparam int DW    = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic                    w_wr;
  logic                    w_wr_digits;
  logic                    w_wr_ctrl;
  logic                    w_wr_div;
  logic [DW-1:0]           r_staging;
  logic [DW-1:0]           r_snapshot;
  logic                    r_pend;
  logic                    r_disp_en;
  logic [3:0]              r_mask;
  logic [DIV_W-1:0]        r_div;
  logic [DIV_W-1:0]        r_cnt;
  logic                    r_phase;
  scan_state_t             r_state;
  scan_state_t             w_state_nxt;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic                    w_snap;
  logic                    w_seg_we;
  logic [3:0]              w_nib [NUM_DIGITS];
  logic [3:0]              w_bcd;
  logic [6:0]              w_dec;
  logic [6:0]              w_seg_val;
  logic [6:0]              r_seg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   w_blank;
  logic [7*NUM_DIGITS-1:0] r_hex;
  logic                    w_unused_wdata;

  assign w_wr        = chipselect & ~write_n;
  assign w_wr_digits = w_wr & (address == REG_DIGITS);
  assign w_wr_ctrl   = w_wr & (address == REG_CTRL);
  assign w_wr_div    = w_wr & (address == REG_BLINK_DIV);
  assign scan_busy   = (r_state != IDLE);
  assign hex_out     = r_hex;

  // Upper write-data bits have no register behind them
  assign w_unused_wdata = ^writedata;

  // Software-visible configuration and staging registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_staging <= '0;
      r_disp_en <= 1'b0;
      r_mask    <= '0;
      r_div     <= '0;
    end else begin
      if (w_wr_digits) r_staging <= writedata[DW-1:0];
      if (w_wr_ctrl) begin
        r_disp_en <= writedata[0];
        r_mask    <= writedata[7:4];
      end
      if (w_wr_div) r_div <= writedata[DIV_W-1:0];
    end
  end

  // Pending flag: a new DIGITS write beats the clear issued by SNAP
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         r_pend <= 1'b1;
    else if (w_wr_digits) r_pend <= 1'b1;
    else if (w_snap)      r_pend <= 1'b0;
  end

  // Scan sequencer state and digit index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Scan sequencer next-state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_snap      = 1'b0;
    w_seg_we    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pend) w_state_nxt = SNAP;
      end
      SNAP: begin
        w_snap      = 1'b1;
        w_idx_nxt   = '0;
        w_state_nxt = SCAN;
      end
      SCAN: begin
        w_seg_we = 1'b1;
        if (r_idx == C_LAST_IDX) w_state_nxt = DONE;
        else                     w_idx_nxt   = r_idx + IDX_W'(1);
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Freeze the staged digits for the duration of one scan
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_snapshot <= '0;
    else if (w_snap) r_snapshot <= r_staging;
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
    assign w_nib[gi] = r_snapshot[4*gi +: 4];
  end

  assign w_bcd = w_nib[r_idx];

  cpu_nios_sevseg_decoder u_decoder (
    .i_bcd (w_bcd),
    .o_seg (w_dec)
  );

`ifdef LEADING_ZERO_BLANK_EN
  assign w_seg_val = ((r_idx == C_LAST_IDX) && (w_bcd == 4'd0)) ? SEG_BLANK : w_dec;
`else
  assign w_seg_val = w_dec;
`endif

  // Blink prescaler: half-period counter toggling phase; div=0 holds phase on
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (w_wr_div) begin
      r_cnt <= writedata[DIV_W-1:0];
      if (writedata[DIV_W-1:0] == '0) r_phase <= 1'b1;
    end else if (r_div == '0) begin
      r_cnt   <= r_div;
      r_phase <= 1'b1;
    end else if (r_cnt == '0) begin
      r_cnt   <= r_div;
      r_phase <= ~r_phase;
    end else begin
      r_cnt <= r_cnt - DIV_W'(1);
    end
  end

  // Per-digit blanking condition; only the first four digits are maskable
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
    if (gi < 4) begin : g_maskable
      assign w_blank[gi] = !r_disp_en || (r_mask[gi] && !r_phase);
    end else begin : g_fixed
      assign w_blank[gi] = !r_disp_en;
    end
  end

  // Segment latches written by the scan, and the registered output stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_seg[i] <= SEG_BLANK;
      r_hex <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_seg_we && (r_idx == IDX_W'(i))) r_seg[i] <= w_seg_val;
        r_hex[7*i +: 7] <= w_blank[i] ? SEG_BLANK : r_seg[i];
      end
    end
  end

  // Zero-latency read mux
  always_comb begin
    readdata = '0;
    case (address)
      REG_DIGITS:    readdata[DW-1:0]    = r_staging;
      REG_CTRL: begin
        readdata[0]   = r_disp_en;
        readdata[7:4] = r_mask;
      end
      REG_BLINK_DIV: readdata[DIV_W-1:0] = r_div;
      REG_STATUS:    readdata[2:0]       = {scan_busy, r_pend, r_phase};
      default:       readdata            = '0;
    endcase
  end

endmodule
`default_nettype wire
